lp_sched_monitor: RTL and testbench

Next-generation core/LP conflict monitor for the PDES engine. It sits between the event queue dispatcher and the core array, tracking which LP and timestamp each core holds. It serialises cores working on the same LP, releasing waiters in timestamp order. Compared with the previous monitor it has:
- separate dispatch and retire channels that may fire in the same cycle;
- an explicit per-core state machine;
- per-core stall-age counters with starvation flags;
- error flags for protocol violations.

---
 rtl/lp_sched_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_lp_sched_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lp_sched_monitor.sv
// rtl/lp_sched_monitor.sv - core/LP conflict monitor with ordered release and starvation tracking
module lp_sched_monitor #(
  parameter int NUM_CORE      = 4,
  parameter int NB_COREID     = $clog2(NUM_CORE),
  parameter int NUM_LP        = 8,
  parameter int NB_LPID       = $clog2(NUM_LP),
  parameter int TIME_WID      = 16,
  parameter int NB_HIST_DEPTH = 4,
  parameter int WAIT_WID      = 8,
  parameter int MAX_WAIT      = 200
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              disp_vld,
  input  logic [NB_COREID-1:0]              disp_core,
  input  logic [NB_LPID-1:0]                disp_lp,
  input  logic [TIME_WID-1:0]               disp_time,
  input  logic                              ret_vld,
  input  logic [NB_COREID-1:0]              ret_core,
  input  logic [NB_HIST_DEPTH-1:0]          ret_hist,
  output logic [NUM_CORE-1:0]               stall,
  output logic [NB_HIST_DEPTH*NUM_CORE-1:0] core_hist_cnt,
  output logic [TIME_WID-1:0]               min_time,
  output logic                              min_time_vld,
  output logic [NUM_CORE-1:0]               starve,
  output logic                              err_disp,
  output logic                              err_ret
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } core_st_t;

  core_st_t                 st     [NUM_CORE];
  core_st_t                 st_nxt [NUM_CORE];
  logic [NB_LPID-1:0]       tbl_lp   [NUM_CORE];
  logic [TIME_WID-1:0]      tbl_time [NUM_CORE];
  logic [NB_HIST_DEPTH-1:0] lp_hist  [NUM_LP];
  logic [NB_HIST_DEPTH-1:0] hist_q   [NUM_CORE];
  logic [WAIT_WID-1:0]      wait_cnt [NUM_CORE];

  logic                     ret_ok;
  logic [NB_LPID-1:0]       ret_lp;
  logic                     disp_ok;
  logic                     rel_found;
  logic [NB_COREID-1:0]     rel_core;
  logic [TIME_WID-1:0]      rel_time;
  logic                     conflict;
  logic [NB_HIST_DEPTH-1:0] disp_hist;
  logic                     tree_vld;
  logic [TIME_WID-1:0]      tree_time;

  // Qualify retire and dispatch against pre-edge core state; retire is judged first
  always_comb begin
    ret_ok  = ret_vld && (st[ret_core] == S_RUN);
    ret_lp  = tbl_lp[ret_core];
    disp_ok = disp_vld && ((st[disp_core] == S_IDLE) || (ret_ok && (disp_core == ret_core)));
    disp_hist = (ret_ok && (ret_lp == disp_lp)) ? ret_hist : lp_hist[disp_lp];
  end

  // Pick the waiter on the retiring core's LP with the smallest time, lowest id on ties
  always_comb begin
    rel_found = 1'b0;
    rel_core  = '0;
    rel_time  = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      if (ret_ok && (st[c] == S_STALL) && (tbl_lp[c] == ret_lp) &&
          (NB_COREID'(c) != ret_core) && !(disp_ok && (NB_COREID'(c) == disp_core))) begin
        if (!rel_found || (tbl_time[c] < rel_time)) begin
          rel_found = 1'b1;
          rel_core  = NB_COREID'(c);
          rel_time  = tbl_time[c];
        end
      end
    end
  end

  // Dispatch conflicts with any other core still busy after this cycle's retire (released cores stay busy)
  always_comb begin
    conflict = 1'b0;
    for (int c = 0; c < NUM_CORE; c++) begin
      if ((NB_COREID'(c) != disp_core) && (st[c] != S_IDLE) &&
          !(ret_ok && (NB_COREID'(c) == ret_core)) && (tbl_lp[c] == disp_lp)) begin
        conflict = 1'b1;
      end
    end
  end

  // Per-core next state: retire, then release, then dispatch (dispatch may reuse the retiring core)
  always_comb begin
    for (int c = 0; c < NUM_CORE; c++) begin
      st_nxt[c] = st[c];
    end
    if (ret_ok) begin
      st_nxt[ret_core] = S_IDLE;
    end
    if (rel_found) begin
      st_nxt[rel_core] = S_RUN;
    end
    if (disp_ok) begin
      st_nxt[disp_core] = conflict ? S_STALL : S_RUN;
    end
  end

  // Core state register
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CORE; c++) begin
      if (!reset) begin
        st[c] <= S_IDLE;
      end else begin
        st[c] <= st_nxt[c];
      end
    end
  end

  // Table of (lp, time) held by each core, written on accepted dispatch
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CORE; c++) begin
        tbl_lp[c]   <= '0;
        tbl_time[c] <= '0;
      end
    end else if (disp_ok) begin
      tbl_lp[disp_core]   <= disp_lp;
      tbl_time[disp_core] <= disp_time;
    end
  end

  // LP history table and per-core history handed out on dispatch/release
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int l = 0; l < NUM_LP; l++) begin
        lp_hist[l] <= '0;
      end
      for (int c = 0; c < NUM_CORE; c++) begin
        hist_q[c] <= '0;
      end
    end else begin
      if (ret_ok) begin
        lp_hist[ret_lp] <= ret_hist;
      end
      if (rel_found) begin
        hist_q[rel_core] <= ret_hist;
      end
      if (disp_ok) begin
        hist_q[disp_core] <= disp_hist;
      end
    end
  end

  // Pack per-core history onto the flat output bus
  always_comb begin
    core_hist_cnt = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      core_hist_cnt[c*NB_HIST_DEPTH +: NB_HIST_DEPTH] = hist_q[c];
    end
  end

  // Stall-age counters; stall and starve are registered views of the current state
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CORE; c++) begin
      if (!reset) begin
        wait_cnt[c] <= '0;
        stall[c]    <= 1'b0;
        starve[c]   <= 1'b0;
      end else begin
        if ((st_nxt[c] == S_STALL) && (st[c] == S_STALL)) begin
          if (wait_cnt[c] != {WAIT_WID{1'b1}}) begin
            wait_cnt[c] <= wait_cnt[c] + 1'b1;
          end
        end else begin
          wait_cnt[c] <= '0;
        end
        stall[c]  <= (st[c] == S_STALL);
        starve[c] <= (st[c] == S_STALL) && (wait_cnt[c] >= WAIT_WID'(MAX_WAIT));
      end
    end
  end

  // Reduction-tree minimum of busy cores' timestamps (heap layout, leaves at NUM_CORE..2*NUM_CORE-1)
  always_comb begin
    logic                nd_v [2*NUM_CORE];
    logic [TIME_WID-1:0] nd_t [2*NUM_CORE];
    for (int i = 0; i < 2*NUM_CORE; i++) begin
      nd_v[i] = 1'b0;
      nd_t[i] = '0;
    end
    for (int c = 0; c < NUM_CORE; c++) begin
      nd_v[NUM_CORE+c] = (st[c] != S_IDLE);
      nd_t[NUM_CORE+c] = tbl_time[c];
    end
    for (int i = NUM_CORE-1; i >= 1; i--) begin
      nd_v[i] = nd_v[2*i] || nd_v[2*i+1];
      if (nd_v[2*i] && nd_v[2*i+1]) begin
        nd_t[i] = (nd_t[2*i+1] < nd_t[2*i]) ? nd_t[2*i+1] : nd_t[2*i];
      end else if (nd_v[2*i+1]) begin
        nd_t[i] = nd_t[2*i+1];
      end else begin
        nd_t[i] = nd_t[2*i];
      end
    end
    tree_vld  = nd_v[1];
    tree_time = nd_v[1] ? nd_t[1] : '0;
  end

  // Register the minimum timestamp of busy cores
  always_ff @(posedge clk) begin
    if (!reset) begin
      min_time     <= '0;
      min_time_vld <= 1'b0;
    end else begin
      min_time     <= tree_time;
      min_time_vld <= tree_vld;
    end
  end

  // Sticky protocol error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_disp <= 1'b0;
      err_ret  <= 1'b0;
    end else begin
      err_disp <= err_disp | (disp_vld && !disp_ok);
      err_ret  <= err_ret  | (ret_vld && !ret_ok);
    end
  end

endmodule

// File: tb/tb_lp_sched_monitor.sv
// tb/tb_lp_sched_monitor.sv - directed self-checking bench for lp_sched_monitor
module tb_lp_sched_monitor;

  localparam int NUM_CORE = 4;
  localparam int NB_COREID = 2;
  localparam int NUM_LP = 8;
  localparam int NB_LPID = 3;
  localparam int TIME_WID = 16;
  localparam int NBH = 4;
  localparam int WAIT_WID = 8;
  localparam int MAX_WAIT = 10;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     disp_vld;
  logic [NB_COREID-1:0]     disp_core;
  logic [NB_LPID-1:0]       disp_lp;
  logic [TIME_WID-1:0]      disp_time;
  logic                     ret_vld;
  logic [NB_COREID-1:0]     ret_core;
  logic [NBH-1:0]           ret_hist;
  logic [NUM_CORE-1:0]      stall;
  logic [NBH*NUM_CORE-1:0]  core_hist_cnt;
  logic [TIME_WID-1:0]      min_time;
  logic                     min_time_vld;
  logic [NUM_CORE-1:0]      starve;
  logic                     err_disp;
  logic                     err_ret;

  int n_tests = 0;
  int n_fail = 0;

  lp_sched_monitor #(
    .NUM_CORE(NUM_CORE), .NB_COREID(NB_COREID), .NUM_LP(NUM_LP), .NB_LPID(NB_LPID),
    .TIME_WID(TIME_WID), .NB_HIST_DEPTH(NBH), .WAIT_WID(WAIT_WID), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_vld(disp_vld), .disp_core(disp_core), .disp_lp(disp_lp), .disp_time(disp_time),
    .ret_vld(ret_vld), .ret_core(ret_core), .ret_hist(ret_hist),
    .stall(stall), .core_hist_cnt(core_hist_cnt), .min_time(min_time), .min_time_vld(min_time_vld),
    .starve(starve), .err_disp(err_disp), .err_ret(err_ret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [NBH-1:0] hist_of(input int c);
    return core_hist_cnt[c*NBH +: NBH];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input int c, input int lp, input int t);
    disp_vld = 1'b1; disp_core = NB_COREID'(c); disp_lp = NB_LPID'(lp); disp_time = TIME_WID'(t);
    cyc();
    disp_vld = 1'b0;
  endtask

  task automatic retire(input int c, input int h);
    ret_vld = 1'b1; ret_core = NB_COREID'(c); ret_hist = NBH'(h);
    cyc();
    ret_vld = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; disp_vld = 1'b0; ret_vld = 1'b0;
    disp_core = '0; disp_lp = '0; disp_time = '0; ret_core = '0; ret_hist = '0;
    cyc(); cyc();
    reset = 1'b1;
    n_tests++; if (stall !== 4'b0000) begin n_fail++; $display("FAIL reset_stall: got %b expected 0000", stall); end
    n_tests++; if (starve !== 4'b0000) begin n_fail++; $display("FAIL reset_starve: got %b expected 0000", starve); end
    n_tests++; if (min_time_vld !== 1'b0 || min_time !== 16'd0) begin n_fail++; $display("FAIL reset_min: got vld=%b t=%0d expected 0/0", min_time_vld, min_time); end
    n_tests++; if (core_hist_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_hist: got %h expected 0000", core_hist_cnt); end
    n_tests++; if (err_disp !== 1'b0 || err_ret !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", err_disp, err_ret); end
  endtask

  task automatic test_disjoint();
    dispatch(0, 2, 10);
    dispatch(1, 3, 5);
    cyc();
    n_tests++; if (stall !== 4'b0000) begin n_fail++; $display("FAIL disjoint_stall: got %b expected 0000", stall); end
    n_tests++; if (min_time !== 16'd5 || min_time_vld !== 1'b1) begin n_fail++; $display("FAIL disjoint_min: got vld=%b t=%0d expected 1/5", min_time_vld, min_time); end
    retire(0, 0);
    retire(1, 0);
    cyc();
    n_tests++; if (min_time_vld !== 1'b0 || min_time !== 16'd0) begin n_fail++; $display("FAIL disjoint_idle_min: got vld=%b t=%0d expected 0/0", min_time_vld, min_time); end
  endtask

  task automatic test_conflict_release();
    dispatch(0, 1, 4);
    dispatch(2, 1, 9);
    dispatch(3, 1, 7);
    cyc();
    n_tests++; if (stall !== 4'b1100) begin n_fail++; $display("FAIL conflict_stall: got %b expected 1100", stall); end
    retire(0, 3);
    n_tests++; if (hist_of(3) !== 4'd3) begin n_fail++; $display("FAIL release_hist3: got %0d expected 3", hist_of(3)); end
    cyc();
    n_tests++; if (stall !== 4'b0100) begin n_fail++; $display("FAIL release_stall: got %b expected 0100", stall); end
    n_tests++; if (min_time !== 16'd7 || min_time_vld !== 1'b1) begin n_fail++; $display("FAIL release_min: got vld=%b t=%0d expected 1/7", min_time_vld, min_time); end
    retire(3, 5);
    n_tests++; if (hist_of(2) !== 4'd5) begin n_fail++; $display("FAIL release_hist2: got %0d expected 5", hist_of(2)); end
    cyc();
    n_tests++; if (stall !== 4'b0000) begin n_fail++; $display("FAIL release2_stall: got %b expected 0000", stall); end
    retire(2, 1);
  endtask

  task automatic test_tie_break();
    dispatch(0, 5, 1);
    dispatch(1, 5, 20);
    dispatch(3, 5, 20);
    cyc();
    n_tests++; if (stall !== 4'b1010) begin n_fail++; $display("FAIL tie_stall: got %b expected 1010", stall); end
    retire(0, 2);
    n_tests++; if (hist_of(1) !== 4'd2) begin n_fail++; $display("FAIL tie_hist1: got %0d expected 2", hist_of(1)); end
    cyc();
    n_tests++; if (stall !== 4'b1000) begin n_fail++; $display("FAIL tie_release: got %b expected 1000", stall); end
    retire(1, 4);
    retire(3, 4);
  endtask

  task automatic test_back_to_back();
    dispatch(0, 4, 30);
    ret_vld = 1'b1; ret_core = 2'd0; ret_hist = 4'd6;
    disp_vld = 1'b1; disp_core = 2'd1; disp_lp = 3'd4; disp_time = 16'd31;
    cyc();
    ret_vld = 1'b0; disp_vld = 1'b0;
    n_tests++; if (hist_of(1) !== 4'd6) begin n_fail++; $display("FAIL b2b_fwd_hist: got %0d expected 6", hist_of(1)); end
    cyc();
    n_tests++; if (stall !== 4'b0000) begin n_fail++; $display("FAIL b2b_stall: got %b expected 0000", stall); end
    n_tests++; if (min_time !== 16'd31) begin n_fail++; $display("FAIL b2b_min: got %0d expected 31", min_time); end
    retire(1, 7);
    dispatch(0, 4, 40);
    n_tests++; if (hist_of(0) !== 4'd7) begin n_fail++; $display("FAIL b2b_lp_hist: got %0d expected 7", hist_of(0)); end
    dispatch(2, 4, 41);
    ret_vld = 1'b1; ret_core = 2'd0; ret_hist = 4'd8;
    disp_vld = 1'b1; disp_core = 2'd1; disp_lp = 3'd4; disp_time = 16'd42;
    cyc();
    ret_vld = 1'b0; disp_vld = 1'b0;
    n_tests++; if (hist_of(2) !== 4'd8 || hist_of(1) !== 4'd8) begin n_fail++; $display("FAIL b2b2_hist: got c2=%0d c1=%0d expected 8/8", hist_of(2), hist_of(1)); end
    cyc();
    n_tests++; if (stall !== 4'b0010) begin n_fail++; $display("FAIL b2b2_stall: got %b expected 0010", stall); end
    n_tests++; if (err_disp !== 1'b0 || err_ret !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b%b expected 00", err_disp, err_ret); end
    retire(2, 9);
    retire(1, 9);
  endtask

  task automatic test_starvation();
    dispatch(0, 6, 50);
    dispatch(1, 6, 51);
    for (int i = 0; i < 10; i++) cyc();
    n_tests++; if (starve !== 4'b0000) begin n_fail++; $display("FAIL starve_early: got %b expected 0000", starve); end
    n_tests++; if (stall !== 4'b0010) begin n_fail++; $display("FAIL starve_stall: got %b expected 0010", stall); end
    cyc();
    n_tests++; if (starve !== 4'b0010) begin n_fail++; $display("FAIL starve_set: got %b expected 0010", starve); end
    retire(0, 1);
    cyc();
    n_tests++; if (starve !== 4'b0000 || stall !== 4'b0000) begin n_fail++; $display("FAIL starve_clear: got starve=%b stall=%b expected 0000/0000", starve, stall); end
    retire(1, 1);
  endtask

  task automatic test_errors_reset();
    dispatch(0, 7, 60);
    n_tests++; if (err_disp !== 1'b0) begin n_fail++; $display("FAIL err_disp_pre: got %b expected 0", err_disp); end
    dispatch(0, 0, 61);
    n_tests++; if (err_disp !== 1'b1) begin n_fail++; $display("FAIL err_disp_set: got %b expected 1", err_disp); end
    cyc();
    n_tests++; if (min_time !== 16'd60 || stall !== 4'b0000) begin n_fail++; $display("FAIL err_disp_state: got t=%0d stall=%b expected 60/0000", min_time, stall); end
    n_tests++; if (err_ret !== 1'b0) begin n_fail++; $display("FAIL err_ret_pre: got %b expected 0", err_ret); end
    retire(2, 3);
    n_tests++; if (err_ret !== 1'b1) begin n_fail++; $display("FAIL err_ret_set: got %b expected 1", err_ret); end
    dispatch(1, 7, 62);
    cyc();
    n_tests++; if (stall !== 4'b0010) begin n_fail++; $display("FAIL pre_reset_stall: got %b expected 0010", stall); end
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    n_tests++; if (stall !== 4'b0000 || starve !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_stall: got stall=%b starve=%b expected 0000/0000", stall, starve); end
    n_tests++; if (min_time_vld !== 1'b0 || min_time !== 16'd0 || core_hist_cnt !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_out: got vld=%b t=%0d hist=%h expected 0/0/0000", min_time_vld, min_time, core_hist_cnt); end
    n_tests++; if (err_disp !== 1'b0 || err_ret !== 1'b0) begin n_fail++; $display("FAIL mid_reset_err: got %b%b expected 00", err_disp, err_ret); end
    dispatch(2, 4, 1);
    n_tests++; if (hist_of(2) !== 4'd0) begin n_fail++; $display("FAIL reset_lp_hist: got %0d expected 0", hist_of(2)); end
    cyc();
    n_tests++; if (stall !== 4'b0000 || min_time !== 16'd1) begin n_fail++; $display("FAIL post_reset_run: got stall=%b t=%0d expected 0000/1", stall, min_time); end
  endtask

  initial begin
    test_reset();
    test_disjoint();
    test_conflict_release();
    test_tie_break();
    test_back_to_back();
    test_starvation();
    test_errors_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
